// File: rtl/rgb_fader_pkg.sv
// Shared types and helpers for the RGB colour fader.
package rgb_fader_pkg;

    localparam int DUTY_W = 8;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef struct packed {
        duty_t r;
        duty_t g;
        duty_t b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FADE = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Move one LSB toward the target; never overshoots and never wraps.
    function automatic duty_t step_toward(duty_t cur, duty_t tgt);
        if (cur < tgt) begin
            return cur + 1'b1;
        end else if (cur > tgt) begin
            return cur - 1'b1;
        end else begin
            return cur;
        end
    endfunction

endpackage

// File: rtl/rgb_fader_tick.sv
// Step-rate divider: pulses tick once every DIV enabled cycles, parked at 0 when disabled.
module tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next count: clear on request or when idle, wrap after the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rgb_fader.sv
// Ramps three 8-bit PWM duties toward an accepted target colour, holds, then reports done.
module rgb_fader
    import rgb_fader_pkg::*;
#(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int STEP_FREQ  = 1_000,
    parameter int HOLD_STEPS = 250
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                tgt_valid,
    output logic                tgt_ready,
    input  logic [3*DUTY_W-1:0] tgt_rgb,
    output logic [DUTY_W-1:0]   duty_r,
    output logic [DUTY_W-1:0]   duty_g,
    output logic [DUTY_W-1:0]   duty_b,
    output logic                busy,
    output logic                done
);

    localparam int DIV_RAW = CLK_FREQ / STEP_FREQ;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int HW_RAW  = $clog2(HOLD_STEPS + 1);
    localparam int HW      = (HW_RAW < 1) ? 1 : HW_RAW;
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

    state_e        state_q, state_d;
    rgb_t          duty_q, duty_d;
    rgb_t          tgt_q, tgt_d;
    rgb_t          step_rgb;
    logic [HW-1:0] hold_q, hold_d;
    logic          done_q, done_d;
    logic          tick;
    logic          accept;

    assign accept = tgt_valid && (state_q == IDLE);

    tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .clr    (accept),
        .en     (state_q != IDLE),
        .tick   (tick)
    );

    // Candidate duties one step closer to the latched target.
    always_comb begin
        step_rgb   = duty_q;
        step_rgb.r = step_toward(duty_q.r, tgt_q.r);
        step_rgb.g = step_toward(duty_q.g, tgt_q.g);
        step_rgb.b = step_toward(duty_q.b, tgt_q.b);
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (rgb_t'(tgt_rgb) == duty_q) ? HOLD : FADE;
                end
            end
            FADE: begin
                if (tick && (step_rgb == tgt_q)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (HOLD_STEPS == 0) begin
                    state_d = IDLE;
                end else if (tick && (hold_q == HOLD_LAST)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: target latch, duty stepping, hold count, done pulse.
    always_comb begin
        tgt_d  = tgt_q;
        duty_d = duty_q;
        hold_d = hold_q;
        done_d = (state_q == HOLD) && (state_d == IDLE);
        if (accept) begin
            tgt_d = rgb_t'(tgt_rgb);
        end
        if ((state_q == FADE) && tick) begin
            duty_d = step_rgb;
        end
        if ((state_q != HOLD) && (state_d == HOLD)) begin
            hold_d = '0;
        end else if ((state_q == HOLD) && tick) begin
            hold_d = hold_q + 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tgt_q  <= '0;
            duty_q <= '0;
            hold_q <= '0;
            done_q <= 1'b0;
        end else begin
            tgt_q  <= tgt_d;
            duty_q <= duty_d;
            hold_q <= hold_d;
            done_q <= done_d;
        end
    end

    // Output decode.
    always_comb begin
        tgt_ready = (state_q == IDLE);
        busy      = (state_q == FADE) || (state_q == HOLD);
        done      = done_q;
        duty_r    = duty_q.r;
        duty_g    = duty_q.g;
        duty_b    = duty_q.b;
    end

endmodule

// File: tb/tb_rgb_fader.sv
// Self-checking bench for rgb_fader with DIV=10, HOLD_STEPS=2.
module tb_rgb_fader;

    localparam int DIV = 10;
    localparam int H   = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        tgt_valid = 1'b0;
    logic        tgt_ready;
    logic [23:0] tgt_rgb = '0;
    logic [7:0]  duty_r, duty_g, duty_b;
    logic        busy, done;

    int checks   = 0;
    int failures = 0;
    logic [23:0] cur = '0;

    rgb_fader #(
        .CLK_FREQ   (100),
        .STEP_FREQ  (10),
        .HOLD_STEPS (H)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_rgb   (tgt_rgb),
        .duty_r    (duty_r),
        .duty_g    (duty_g),
        .duty_b    (duty_b),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    function automatic int absdiff(int a, int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int fade_len(logic [23:0] s, logic [23:0] t);
        int m;
        m = absdiff(int'(s[23:16]), int'(t[23:16]));
        if (absdiff(int'(s[15:8]), int'(t[15:8])) > m) m = absdiff(int'(s[15:8]), int'(t[15:8]));
        if (absdiff(int'(s[7:0]), int'(t[7:0])) > m) m = absdiff(int'(s[7:0]), int'(t[7:0]));
        return m;
    endfunction

    // Cycle (counted from the accept edge) on which the block re-enters IDLE.
    function automatic int end_edge(logic [23:0] s, logic [23:0] t);
        return (H > 0) ? (fade_len(s, t) + H) * DIV : fade_len(s, t) * DIV + 1;
    endfunction

    // Channel value after k whole steps from s toward t.
    function automatic logic [7:0] ch_at(int s, int t, int k);
        int d;
        d = absdiff(s, t);
        if (k > d) k = d;
        return 8'((t >= s) ? s + k : s - k);
    endfunction

    // Expected {duty_r, duty_g, duty_b, busy, done, tgt_ready} n cycles after accept edge.
    function automatic logic [26:0] expect_at(logic [23:0] s, logic [23:0] t, int n);
        int   k, e;
        logic b, d;
        k = n / DIV;
        e = end_edge(s, t);
        b = (n < e);
        d = (n == e);
        return {ch_at(int'(s[23:16]), int'(t[23:16]), k),
                ch_at(int'(s[15:8]),  int'(t[15:8]),  k),
                ch_at(int'(s[7:0]),   int'(t[7:0]),   k),
                b, d, !b};
    endfunction

    function automatic logic [26:0] observed();
        return {duty_r, duty_g, duty_b, busy, done, tgt_ready};
    endfunction

    // Offer a target at a negedge and return just after the accepting edge.
    task automatic offer(input logic [23:0] t, input bit keep);
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_rgb   = t;
        @(posedge clk);
        #1;
        if (!keep) tgt_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (observed() !== {24'h0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_held got=%h want=%h", observed(), {24'h0, 1'b0, 1'b0, 1'b1});
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (observed() !== {24'h0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_release got=%h want=%h", observed(), {24'h0, 1'b0, 1'b0, 1'b1});
        end
        cur = 24'h0;
    endtask

    task automatic test_fade(input string name, input logic [23:0] t);
        logic [23:0] s;
        int e;
        s = cur;
        e = end_edge(s, t);
        offer(t, 1'b0);
        for (int n = 0; n <= e + 1; n++) begin
            if (n > 0) @(posedge clk);
            @(negedge clk);
            checks++;
            if (observed() !== expect_at(s, t, n)) begin
                failures++;
                $display("FAIL %s n=%0d got=%h want=%h", name, n, observed(), expect_at(s, t, n));
            end
        end
        cur = t;
    endtask

    task automatic test_busy_handshake();
        logic [23:0] s, t1, t2;
        int e;
        s  = cur;
        t1 = 24'h101010;
        t2 = 24'hFF0000;
        e  = end_edge(s, t1);
        offer(t1, 1'b1);
        tgt_rgb = t2;
        for (int n = 0; n <= e; n++) begin
            if (n > 0) @(posedge clk);
            @(negedge clk);
            checks++;
            if (observed() !== expect_at(s, t1, n)) begin
                failures++;
                $display("FAIL busy_hs_first n=%0d got=%h want=%h", n, observed(), expect_at(s, t1, n));
            end
        end
        // valid has stayed high: the edge closing the done cycle is the next accept
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        e = end_edge(t1, t2);
        for (int n = 0; n <= e + 1; n++) begin
            if (n > 0) @(posedge clk);
            @(negedge clk);
            checks++;
            if (observed() !== expect_at(t1, t2, n)) begin
                failures++;
                $display("FAIL busy_hs_second n=%0d got=%h want=%h", n, observed(), expect_at(t1, t2, n));
            end
        end
        cur = t2;
    endtask

    task automatic test_reset_mid_fade();
        logic [23:0] s, t;
        s = cur;
        t = 24'h808080;
        offer(t, 1'b0);
        for (int n = 0; n <= 25; n++) begin
            if (n > 0) @(posedge clk);
            @(negedge clk);
            checks++;
            if (observed() !== expect_at(s, t, n)) begin
                failures++;
                $display("FAIL mid_fade_pre n=%0d got=%h want=%h", n, observed(), expect_at(s, t, n));
            end
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (observed() !== {24'h0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL mid_fade_async got=%h want=%h", observed(), {24'h0, 1'b0, 1'b0, 1'b1});
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            checks++;
            if (observed() !== {24'h0, 1'b0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL mid_fade_after n=%0d got=%h want=%h", n, observed(), {24'h0, 1'b0, 1'b0, 1'b1});
            end
        end
        cur = 24'h0;
    endtask

    function automatic logic [7:0] near(logic [7:0] c);
        int v;
        v = int'(c) + int'($urandom_range(0, 24)) - 12;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    task automatic test_random();
        logic [23:0] t;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) t = 24'($urandom);
            else        t = {near(cur[23:16]), near(cur[15:8]), near(cur[7:0])};
            test_fade("random", t);
        end
    endtask

    initial begin
        test_reset();
        test_fade("upward", 24'h030001);
        test_fade("mixed", 24'h000200);
        test_fade("equal", 24'h000200);
        test_busy_handshake();
        test_reset_mid_fade();
        test_random();
        test_fade("zero_return", 24'h000000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
